// File: rtl/hack_alu_issuer.sv
// Sequential front end for the combinational Hack ALU: accepts one request,
// drives the ALU from registers for a cycle, then holds the result for the consumer.
module hack_alu_issuer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    input  logic [5:0]       req_comp,
    input  logic [2:0]       req_jump,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zr,
    input  logic             alu_ng,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_zr,
    output logic             rsp_ng,
    output logic             rsp_jump,
    output logic [CNT_W-1:0] op_count,
    output logic             flag_mismatch
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0] state;
    logic [2:0] jump_q;
    logic       jump_taken;
    logic       status_bad;

    assign req_ready = (state == IDLE);

    // jump_q is {j_lt, j_eq, j_gt}; "greater" means neither negative nor zero
    assign jump_taken = (jump_q[2] & alu_ng) | (jump_q[1] & alu_zr) |
                        (jump_q[0] & ~alu_ng & ~alu_zr);
    assign status_bad = (alu_zr != (alu_out == '0)) || (alu_ng != alu_out[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            jump_q        <= '0;
            alu_x         <= '0;
            alu_y         <= '0;
            alu_zx        <= 1'b0;
            alu_nx        <= 1'b0;
            alu_zy        <= 1'b0;
            alu_ny        <= 1'b0;
            alu_f         <= 1'b0;
            alu_no        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_out       <= '0;
            rsp_zr        <= 1'b0;
            rsp_ng        <= 1'b0;
            rsp_jump      <= 1'b0;
            op_count      <= '0;
            flag_mismatch <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_x  <= req_x;
                        alu_y  <= req_y;
                        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} <= req_comp;
                        jump_q <= req_jump;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_out   <= alu_out;
                    rsp_zr    <= alu_zr;
                    rsp_ng    <= alu_ng;
                    rsp_jump  <= jump_taken;
                    rsp_valid <= 1'b1;
                    // Sticky: the response is still delivered with whatever the ALU reported
                    if (status_bad)
                        flag_mismatch <= 1'b1;
                    state <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_alu_issuer.sv
// Scoreboard bench for hack_alu_issuer: a behavioural Hack ALU closes the loop,
// expected responses are queued at issue time and popped by an independent monitor.
module tb_hack_alu_issuer;

    typedef struct {
        logic [15:0] out;
        logic        zr;
        logic        ng;
        logic        jmp;
        logic        flag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_x;
    logic [15:0] req_y;
    logic [5:0]  req_comp;
    logic [2:0]  req_jump;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_out;
    logic        rsp_zr;
    logic        rsp_ng;
    logic        rsp_jump;
    logic [15:0] op_count;
    logic        flag_mismatch;

    logic        bad_zr;
    int          total;
    int          passed;
    int          exp_count;
    exp_t        sb[$];

    hack_alu_issuer #(.WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_comp(req_comp), .req_jump(req_jump),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
        .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_zr(rsp_zr), .rsp_ng(rsp_ng), .rsp_jump(rsp_jump),
        .op_count(op_count), .flag_mismatch(flag_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural Hack ALU; bad_zr lets the bench inject an inconsistent status bit
    always_comb begin
        logic [15:0] xs, ys, o;
        xs = alu_zx ? 16'h0000 : alu_x;
        xs = alu_nx ? ~xs : xs;
        ys = alu_zy ? 16'h0000 : alu_y;
        ys = alu_ny ? ~ys : ys;
        o  = alu_f ? (xs + ys) : (xs & ys);
        o  = alu_no ? ~o : o;
        alu_out = o;
        alu_zr  = (o == 16'h0000) && !bad_zr;
        alu_ng  = o[15];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: pops one expectation per response as soon as rsp_valid appears
    initial begin
        logic seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !rsp_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_out", {16'h0, rsp_out}, {16'h0, e.out});
                    checkOutput("rsp_zr", {31'h0, rsp_zr}, {31'h0, e.zr});
                    checkOutput("rsp_ng", {31'h0, rsp_ng}, {31'h0, e.ng});
                    checkOutput("rsp_jump", {31'h0, rsp_jump}, {31'h0, e.jmp});
                    checkOutput("flag_mismatch", {31'h0, flag_mismatch}, {31'h0, e.flag});
                end
            end
        end
    end

    task automatic sendReq(input logic [15:0] x, input logic [15:0] y,
                           input logic [5:0] comp, input logic [2:0] jump);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready)
            checkOutput("req_ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1;
        req_x     = x;
        req_y     = y;
        req_comp  = comp;
        req_jump  = jump;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_x     = 16'hDEAD;
        req_y     = 16'hBEEF;
        checkOutput("req_ready_exec", {31'h0, req_ready}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                                 input logic [5:0] comp, input logic [2:0] jump,
                                 input logic [15:0] eout, input logic ezr, input logic eng,
                                 input logic ejmp, input logic eflag, input int bp);
        exp_t e;
        e.out = eout; e.zr = ezr; e.ng = eng; e.jmp = ejmp; e.flag = eflag;
        sb.push_back(e);
        sendReq(x, y, comp, jump);
        checkOutput("rsp_valid_edge1", {31'h0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rsp_valid_edge2", {31'h0, rsp_valid}, 32'd1);
        // Backpressure: junk requests must be ignored and the response must not move
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_x     = 16'h1234 + 16'(i);
            req_comp  = 6'b111111;
            @(posedge clk);
            #1;
            checkOutput("bp_rsp_valid", {31'h0, rsp_valid}, 32'd1);
            checkOutput("bp_rsp_out", {16'h0, rsp_out}, {16'h0, eout});
            checkOutput("bp_req_ready", {31'h0, req_ready}, 32'd0);
            checkOutput("bp_alu_x", {16'h0, alu_x}, {16'h0, x});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_count++;
        checkOutput("rsp_valid_after_hs", {31'h0, rsp_valid}, 32'd0);
        checkOutput("op_count", {16'h0, op_count}, exp_count);
        checkOutput("req_ready_after_hs", {31'h0, req_ready}, 32'd1);
        checkOutput("rsp_out_retained", {16'h0, rsp_out}, {16'h0, eout});
        checkOutput("alu_x_held", {16'h0, alu_x}, {16'h0, x});
    endtask

    task automatic resetCheck(input string tag);
        rst_n = 1'b0;
        #1;
        exp_count = 0;
        checkOutput({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'd0);
        checkOutput({tag, "_op_count"}, {16'h0, op_count}, 32'd0);
        checkOutput({tag, "_flag"}, {31'h0, flag_mismatch}, 32'd0);
        checkOutput({tag, "_alu_x"}, {16'h0, alu_x}, 32'd0);
        checkOutput({tag, "_rsp_out"}, {16'h0, rsp_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput({tag, "_req_ready"}, {31'h0, req_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        total     = 0;
        passed    = 0;
        exp_count = 0;
        bad_zr    = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_comp  = '0;
        req_jump  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        checkOutput("reset_alu_ctrl", {26'h0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'd0);
        checkOutput("reset_rsp_jump", {31'h0, rsp_jump}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_req_ready", {31'h0, req_ready}, 32'd1);

        // Constant zero, JEQ
        applyStimulus(16'h0000, 16'hFFFF, 6'b101010, 3'b010, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        // -1 with JLT, then 1 with JLT
        applyStimulus(16'h0000, 16'hFFFF, 6'b111010, 3'b100, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        applyStimulus(16'h0000, 16'hFFFF, 6'b111111, 3'b100, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        // x|y with JGT, then x&y under backpressure
        applyStimulus(16'h0011, 16'h0003, 6'b010101, 3'b001, 16'h0013, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        applyStimulus(16'h0011, 16'h0003, 6'b000000, 3'b001, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 5);

        // Abort during EXEC: nothing will be delivered
        sendReq(16'h0005, 16'h0000, 6'b001100, 3'b111);
        resetCheck("rst_exec");
        // Abort during HOLD: the response appears once, then is discarded
        begin
            exp_t e;
            e.out = 16'h0005; e.zr = 1'b0; e.ng = 1'b0; e.jmp = 1'b1; e.flag = 1'b0;
            sb.push_back(e);
        end
        sendReq(16'h0005, 16'h0000, 6'b001100, 3'b001);
        @(posedge clk);
        @(negedge clk);
        #1;
        resetCheck("rst_hold");

        applyStimulus(16'h0005, 16'h0000, 6'b001100, 3'b001, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, 0);

        // Inconsistent status from the ALU, then a clean op with the flag still set
        bad_zr = 1'b1;
        applyStimulus(16'h0000, 16'hFFFF, 6'b101010, 3'b001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        bad_zr = 1'b0;
        applyStimulus(16'h0011, 16'h0003, 6'b010101, 3'b010, 16'h0013, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        checkOutput("flag_sticky", {31'h0, flag_mismatch}, 32'd1);
        resetCheck("rst_flag");

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
